// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_burst_ctrl                                               |
// | Description : Bridges a core load/store/instruction-fetch request port     |
// |               onto a single-cycle-latency SRAM. Supports masked 64-bit     |
// |               writes, single 64-bit reads and aligned 8-beat bursts that   |
// |               assemble a 512-bit instruction line.                         |
// | Ports       : clock, reset_n (sync, active-low)                            |
// |               ddr_* : core side request / response, ddr_ready in IDLE,     |
// |                       ddr_operation_done one-cycle completion pulse        |
// |               sram_*: SRAM strobe, write enable, word address, bit mask,   |
// |                       write data; sram_rdata valid 1 cycle after a read    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_burst_ctrl (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ddr_chip_enable,
  input  logic [18:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [63:0]  ddr_opstore_write_mask,
  input  logic [63:0]  ddr_opstore_write_data,
  output logic [63:0]  ddr_opload_read_data,
  output logic [511:0] ddr_pc_read_inst,
  output logic         ddr_operation_done,
  output logic         ddr_ready,
  output logic         sram_ce,
  output logic         sram_we,
  output logic [18:0]  sram_addr,
  output logic [63:0]  sram_wmask,
  output logic [63:0]  sram_wdata,
  input  logic [63:0]  sram_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    BURST    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  // Request fields captured at acceptance; core inputs are ignored afterwards.
  logic [18:0]  r_index;
  logic         r_we;
  logic         r_burst;
  logic [63:0]  r_mask;
  logic [63:0]  r_data;

  // Burst sequencing: r_beat is the beat being issued; r_issued_all marks the
  // extra capture-only cycle after beat 7 has gone out.
  logic [2:0]   r_beat;
  logic         r_issued_all;
  // A beat issued in cycle N returns data in cycle N+1; remember which slot.
  logic         r_cap_valid;
  logic [2:0]   r_cap_beat;

  logic [63:0]  r_opload;
  logic [511:0] r_pc;

  logic         w_accept;
  logic         w_burst_issue;

  assign w_accept      = (r_state == IDLE) && ddr_chip_enable;
  assign w_burst_issue = (r_state == BURST) && r_burst && !r_issued_all;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next             = r_state;
    ddr_ready          = 1'b0;
    ddr_operation_done = 1'b0;
    sram_ce            = 1'b0;
    sram_we            = 1'b0;
    sram_addr          = r_index;
    case (r_state)
      IDLE: begin
        ddr_ready = 1'b1;
        if (ddr_chip_enable) begin
          if (ddr_write_enable)    w_next = WR;
          else if (ddr_burst_mode) w_next = BURST;
          else                     w_next = RD_ISSUE;
        end
      end
      WR: begin
        sram_ce = 1'b1;
        sram_we = r_we;
        w_next  = DONE;
      end
      RD_ISSUE: begin
        sram_ce = 1'b1;
        w_next  = RD_WAIT;
      end
      RD_WAIT: begin
        w_next = DONE;
      end
      BURST: begin
        // Aligned base with the beat counter in the low bits: never crosses
        // the 8-word boundary and never wraps the address space.
        sram_addr = {r_index[18:3], r_beat};
        sram_ce   = w_burst_issue;
        if (r_issued_all) w_next = DONE;
      end
      DONE: begin
        ddr_operation_done = 1'b1;
        w_next             = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_index      <= 19'd0;
      r_we         <= 1'b0;
      r_burst      <= 1'b0;
      r_mask       <= 64'd0;
      r_data       <= 64'd0;
      r_beat       <= 3'd0;
      r_issued_all <= 1'b0;
      r_cap_valid  <= 1'b0;
      r_cap_beat   <= 3'd0;
      r_opload     <= 64'd0;
      r_pc         <= 512'd0;
    end else begin
      r_cap_valid <= w_burst_issue;
      r_cap_beat  <= r_beat;
      if (w_accept) begin
        r_index      <= ddr_index;
        r_we         <= ddr_write_enable;
        r_burst      <= ddr_burst_mode;
        r_mask       <= ddr_opstore_write_mask;
        r_data       <= ddr_opstore_write_data;
        r_beat       <= 3'd0;
        r_issued_all <= 1'b0;
      end else if (w_burst_issue) begin
        r_beat <= r_beat + 3'd1;
        if (r_beat == 3'd7) r_issued_all <= 1'b1;
      end
      if (r_state == RD_WAIT) begin
        r_opload <= sram_rdata;
      end
      if (r_cap_valid) begin
        r_pc[{r_cap_beat, 6'd0} +: 64] <= sram_rdata;
      end
    end
  end

  assign sram_wmask           = r_mask;
  assign sram_wdata           = r_data;
  assign ddr_opload_read_data = r_opload;
  assign ddr_pc_read_inst     = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_burst_ctrl                                            |
// | Description : Self-checking bench for mem_burst_ctrl with a behavioural   |
// |               1-cycle SRAM and a scoreboard of expected SRAM accesses      |
// |               and expected read results.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_burst_ctrl;

  typedef struct packed {
    logic        we;
    logic [18:0] addr;
    logic [63:0] mask;
    logic [63:0] data;
  } acc_t;

  logic         clock;
  logic         reset_n;
  logic         ddr_chip_enable;
  logic [18:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [63:0]  ddr_opstore_write_mask;
  logic [63:0]  ddr_opstore_write_data;
  logic [63:0]  ddr_opload_read_data;
  logic [511:0] ddr_pc_read_inst;
  logic         ddr_operation_done;
  logic         ddr_ready;
  logic         sram_ce;
  logic         sram_we;
  logic [18:0]  sram_addr;
  logic [63:0]  sram_wmask;
  logic [63:0]  sram_wdata;
  logic [63:0]  sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  acc_t        exp_q[$];
  logic [63:0] data_q[$];

  mem_burst_ctrl dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .ddr_chip_enable        (ddr_chip_enable),
    .ddr_index              (ddr_index),
    .ddr_write_enable       (ddr_write_enable),
    .ddr_burst_mode         (ddr_burst_mode),
    .ddr_opstore_write_mask (ddr_opstore_write_mask),
    .ddr_opstore_write_data (ddr_opstore_write_data),
    .ddr_opload_read_data   (ddr_opload_read_data),
    .ddr_pc_read_inst       (ddr_pc_read_inst),
    .ddr_operation_done     (ddr_operation_done),
    .ddr_ready              (ddr_ready),
    .sram_ce                (sram_ce),
    .sram_we                (sram_we),
    .sram_addr              (sram_addr),
    .sram_wmask             (sram_wmask),
    .sram_wdata             (sram_wdata),
    .sram_rdata             (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural SRAM: 1024 words, addressed by the low 10 address bits.
  logic [63:0] mem [0:1023];

  function automatic logic [63:0] init_word(int i);
    if (i == 'h20) return 64'hA5A5_0000_FFFF_0001;
    if (i >= 'h38 && i <= 'h3F) return 64'(i);
    if (i >= 'h3F8) return 64'hC0DE_0000_0000_0000 | 64'(i);
    return 64'd0;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      sram_rdata <= 64'd0;
    end else if (sram_ce) begin
      if (sram_we)
        mem[sram_addr[9:0]] <= (mem[sram_addr[9:0]] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else
        sram_rdata <= mem[sram_addr[9:0]];
    end
  end

  function automatic acc_t mk_acc(logic we, logic [18:0] a, logic [63:0] m, logic [63:0] d);
    acc_t e;
    e.we   = we;
    e.addr = a;
    e.mask = m;
    e.data = d;
    return e;
  endfunction

  // Scoreboard monitor: every SRAM strobe must match the oldest expected access.
  initial begin
    acc_t e;
    forever begin
      @(negedge clock);
      if (sram_ce === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sram_unexpected: got we=%b addr=%h, want no access", sram_we, sram_addr);
        end else begin
          e = exp_q.pop_front();
          if (sram_we !== e.we || sram_addr !== e.addr ||
              (e.we && (sram_wmask !== e.mask || sram_wdata !== e.data))) begin
            n_err++;
            $display("FAIL sram_access: got we=%b addr=%h mask=%h data=%h, want we=%b addr=%h mask=%h data=%h",
                     sram_we, sram_addr, sram_wmask, sram_wdata, e.we, e.addr, e.mask, e.data);
          end
        end
      end else if (reset_n === 1'b1) begin
        n_cmp++;
        if (sram_we !== 1'b0) begin
          n_err++;
          $display("FAIL sram_we_idle: got %b want 0", sram_we);
        end
      end
    end
  end

  task automatic drive_req(input logic we, input logic bm, input logic [18:0] idx,
                           input logic [63:0] m, input logic [63:0] d);
    ddr_chip_enable        = 1'b1;
    ddr_write_enable       = we;
    ddr_burst_mode         = bm;
    ddr_index              = idx;
    ddr_opstore_write_mask = m;
    ddr_opstore_write_data = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_req(1'b1, 1'b1, 19'h55, {64{1'b1}}, {64{1'b1}});
    repeat (3) @(negedge clock);
    n_cmp++; if (ddr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ddr_ready); end
    n_cmp++; if (ddr_operation_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", ddr_operation_done); end
    n_cmp++; if (sram_ce !== 1'b0) begin n_err++; $display("FAIL rst_ce: got %b want 0", sram_ce); end
    n_cmp++; if (sram_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", sram_we); end
    n_cmp++; if (sram_addr !== 19'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
    n_cmp++; if (sram_wmask !== 64'd0) begin n_err++; $display("FAIL rst_wmask: got %h want 0", sram_wmask); end
    n_cmp++; if (sram_wdata !== 64'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", sram_wdata); end
    n_cmp++; if (ddr_opload_read_data !== 64'd0) begin n_err++; $display("FAIL rst_opload: got %h want 0", ddr_opload_read_data); end
    n_cmp++; if (ddr_pc_read_inst !== 512'd0) begin n_err++; $display("FAIL rst_pc: got %h want 0", ddr_pc_read_inst); end
    reset_n         = 1'b1;
    ddr_chip_enable = 1'b0;
  endtask

  task automatic test_single_read();
    logic [511:0] pc_before;
    logic [63:0]  exp_d;
    @(negedge clock);
    n_cmp++; if (ddr_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_pre: got %b want 1", ddr_ready); end
    pc_before = ddr_pc_read_inst;
    drive_req(1'b0, 1'b0, 19'h20, 64'hFFFF_0000_FFFF_0000, 64'h1234);
    exp_q.push_back(mk_acc(1'b0, 19'h20, 64'd0, 64'd0));
    data_q.push_back(64'hA5A5_0000_FFFF_0001);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c == 1) ddr_chip_enable = 1'b0;
      n_cmp++; if (sram_ce !== (c == 1)) begin n_err++; $display("FAIL rd_ce: got %b at T+%0d", sram_ce, c); end
      n_cmp++; if (ddr_operation_done !== (c == 3)) begin n_err++; $display("FAIL rd_done: got %b at T+%0d", ddr_operation_done, c); end
      n_cmp++; if (ddr_ready !== (c == 4)) begin n_err++; $display("FAIL rd_ready: got %b at T+%0d", ddr_ready, c); end
      if (c == 3) begin
        exp_d = data_q.pop_front();
        n_cmp++; if (ddr_opload_read_data !== exp_d) begin n_err++; $display("FAIL rd_data: got %h want %h", ddr_opload_read_data, exp_d); end
        n_cmp++; if (ddr_pc_read_inst !== pc_before) begin n_err++; $display("FAIL rd_pc_hold: got %h want %h", ddr_pc_read_inst, pc_before); end
      end
    end
  endtask

  // Shared by the mid-block and top-of-space bursts; all checks live in each test.
  task automatic push_burst(input logic [18:0] idx);
    logic [18:0] a;
    for (int k = 0; k < 8; k++) begin
      a = {idx[18:3], 3'(k)};
      exp_q.push_back(mk_acc(1'b0, a, 64'd0, 64'd0));
      data_q.push_back(init_word(int'(a[9:0])));
    end
  endtask

  task automatic test_burst(input logic [18:0] idx, input string nm);
    logic [511:0] exp_pc;
    logic [63:0]  opl_before;
    @(negedge clock);
    n_cmp++; if (ddr_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_pre: got %b want 1", nm, ddr_ready); end
    opl_before = ddr_opload_read_data;
    drive_req(1'b0, 1'b1, idx, 64'd0, 64'd0);
    push_burst(idx);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      if (c == 1) ddr_chip_enable = 1'b0;
      n_cmp++; if (sram_ce !== (c <= 8)) begin n_err++; $display("FAIL %s_ce: got %b at T+%0d", nm, sram_ce, c); end
      n_cmp++; if (ddr_operation_done !== (c == 10)) begin n_err++; $display("FAIL %s_done: got %b at T+%0d", nm, ddr_operation_done, c); end
      n_cmp++; if (ddr_ready !== (c == 11)) begin n_err++; $display("FAIL %s_ready: got %b at T+%0d", nm, ddr_ready, c); end
      if (c == 10) begin
        for (int k = 0; k < 8; k++) exp_pc[64*k +: 64] = data_q.pop_front();
        n_cmp++; if (ddr_pc_read_inst !== exp_pc) begin n_err++; $display("FAIL %s_pc: got %h want %h", nm, ddr_pc_read_inst, exp_pc); end
        n_cmp++; if (ddr_opload_read_data !== opl_before) begin n_err++; $display("FAIL %s_opload_hold: got %h want %h", nm, ddr_opload_read_data, opl_before); end
      end
    end
  endtask

  task automatic test_write_hold();
    logic [511:0] pc_before;
    logic [63:0]  opl_before;
    @(negedge clock);
    pc_before  = ddr_pc_read_inst;
    opl_before = ddr_opload_read_data;
    drive_req(1'b1, 1'b1, 19'h00010, 64'hFFFF_FFFF_0000_0000, 64'hDEAD_BEEF_1234_5678);
    exp_q.push_back(mk_acc(1'b1, 19'h10, 64'hFFFF_FFFF_0000_0000, 64'hDEAD_BEEF_1234_5678));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c == 1) ddr_chip_enable = 1'b0;
      n_cmp++; if (sram_ce !== (c == 1)) begin n_err++; $display("FAIL wr_ce: got %b at T+%0d", sram_ce, c); end
      n_cmp++; if (ddr_operation_done !== (c == 2)) begin n_err++; $display("FAIL wr_done: got %b at T+%0d", ddr_operation_done, c); end
      n_cmp++; if (ddr_ready !== (c == 3)) begin n_err++; $display("FAIL wr_ready: got %b at T+%0d", ddr_ready, c); end
    end
    n_cmp++; if (ddr_opload_read_data !== opl_before) begin n_err++; $display("FAIL wr_opload_hold: got %h want %h", ddr_opload_read_data, opl_before); end
    n_cmp++; if (ddr_pc_read_inst !== pc_before) begin n_err++; $display("FAIL wr_pc_hold: got %h want %h", ddr_pc_read_inst, pc_before); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d;
    @(negedge clock);
    drive_req(1'b1, 1'b0, 19'h11, {64{1'b1}}, 64'h0123_4567_89AB_CDEF);
    exp_q.push_back(mk_acc(1'b1, 19'h11, {64{1'b1}}, 64'h0123_4567_89AB_CDEF));
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      if (c == 1) begin
        // Held strobe with new read fields while busy: must not start early.
        drive_req(1'b0, 1'b0, 19'h10, 64'd0, 64'd0);
        exp_q.push_back(mk_acc(1'b0, 19'h10, 64'd0, 64'd0));
        data_q.push_back(64'hDEAD_BEEF_0000_0000);
      end
      if (c == 4) ddr_chip_enable = 1'b0;
      n_cmp++; if (sram_ce !== (c == 1 || c == 4)) begin n_err++; $display("FAIL b2b_ce: got %b at T+%0d", sram_ce, c); end
      n_cmp++; if (ddr_operation_done !== (c == 2 || c == 6)) begin n_err++; $display("FAIL b2b_done: got %b at T+%0d", ddr_operation_done, c); end
      n_cmp++; if (ddr_ready !== (c == 3 || c == 7)) begin n_err++; $display("FAIL b2b_ready: got %b at T+%0d", ddr_ready, c); end
      if (c == 6) begin
        exp_d = data_q.pop_front();
        n_cmp++; if (ddr_opload_read_data !== exp_d) begin n_err++; $display("FAIL b2b_rd_data: got %h want %h", ddr_opload_read_data, exp_d); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clock);
    drive_req(1'b0, 1'b1, 19'h3B, 64'd0, 64'd0);
    // Only beats 0..3 go out before reset is sampled at the end of T+4.
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_acc(1'b0, 19'h38 + 19'(k), 64'd0, 64'd0));
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) ddr_chip_enable = 1'b0;
      if (c == 4) reset_n = 1'b0;
      if (c == 5) begin
        n_cmp++; if (sram_ce !== 1'b0) begin n_err++; $display("FAIL mrst_ce: got %b want 0", sram_ce); end
        n_cmp++; if (ddr_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b want 1", ddr_ready); end
        n_cmp++; if (ddr_pc_read_inst !== 512'd0) begin n_err++; $display("FAIL mrst_pc: got %h want 0", ddr_pc_read_inst); end
        reset_n = 1'b1;
      end
      n_cmp++; if (ddr_operation_done !== 1'b0) begin n_err++; $display("FAIL mrst_done: got %b at T+%0d want 0", ddr_operation_done, c); end
    end
    n_cmp++; if (ddr_pc_read_inst !== 512'd0) begin n_err++; $display("FAIL mrst_pc_end: got %h want 0", ddr_pc_read_inst); end
  endtask

  initial begin
    reset_n                = 1'b0;
    ddr_chip_enable        = 1'b0;
    ddr_index              = 19'd0;
    ddr_write_enable       = 1'b0;
    ddr_burst_mode         = 1'b0;
    ddr_opstore_write_mask = 64'd0;
    ddr_opstore_write_data = 64'd0;
    test_reset();
    test_single_read();
    test_burst(19'h3B, "burst");
    test_write_hold();
    test_back_to_back();
    test_burst(19'h7FFFF, "bound");
    test_reset_mid_burst();
    @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sram_missing: got %0d outstanding accesses want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 The block SHALL have no parameters: word width is 64, index width is 19 and burst length is 8 beats, all fixed.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 The ports SHALL be (name  direction  width  meaning):
- clock  in  1  sole clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- ddr_chip_enable  in  1  core request strobe
- ddr_index  in  19  64-bit word index
- ddr_write_enable  in  1  1=write, 0=read
- ddr_burst_mode  in  1  1=8-beat instruction read
- ddr_opstore_write_mask  in  64  bit-granular write mask
- ddr_opstore_write_data  in  64  write data
- ddr_opload_read_data  out  64  single-read result
- ddr_pc_read_inst  out  512  burst-read result
- ddr_operation_done  out  1  one-cycle completion pulse
- ddr_ready  out  1  accepting new request
- sram_ce  out  1  SRAM access strobe
- sram_we  out  1  SRAM write
- sram_addr  out  19  SRAM word address
- sram_wmask  out  64  SRAM bit mask
- sram_wdata  out  64  SRAM write data
- sram_rdata  in  64  SRAM read data, valid exactly 1 cycle after a read strobe

Function
REQ-004 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_WAIT, BURST and DONE; ddr_ready=1 only in IDLE.
REQ-005 A request SHALL be accepted in cycle T iff state is IDLE and ddr_chip_enable=1.
- At acceptance, index, write_enable, burst_mode, mask and data SHALL be registered.
- Core inputs SHALL be ignored in every other cycle; requests made while ddr_ready=0 are dropped, not queued.
REQ-006 Write (write_enable=1; burst_mode ignored):
- IDLE->WR.
- T+1: sram_ce=1, sram_we=1, addr=captured index, sram_wmask and sram_wdata = captured values.
- Then DONE.
REQ-007 Single read (write_enable=0, burst_mode=0):
- T+1, RD_ISSUE: sram_ce=1, sram_we=0, addr=index.
- T+2, RD_WAIT: sram_rdata is registered into ddr_opload_read_data.
- Then DONE.
REQ-008 Burst read (write_enable=0, burst_mode=1):
- Base address = {index[18:3],3'b000}.
- Cycles T+1..T+8, BURST: sram_ce=1, sram_we=0, addr=base+k for k=0..7, from a 3-bit beat counter.
- Data for beat k (returned at T+2+k) SHALL be written to ddr_pc_read_inst[64k+63:64k].
- After the issue of beat 7, the FSM SHALL take one extra BURST cycle to capture beat 7, then go to DONE at T+10.
REQ-009 In DONE, ddr_operation_done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
- Done cycle: write T+2, single read T+3, burst T+10.
- A new request is accepted no earlier than the cycle after DONE.
REQ-010 ddr_opload_read_data SHALL change only on single-read capture; ddr_pc_read_inst SHALL change only on burst captures. Each holds its value otherwise, including across writes.
REQ-011 sram_ce SHALL be 0 in IDLE, RD_WAIT, DONE and the final capture cycle of BURST; sram_we=0 whenever sram_ce=0.
REQ-012 Burst addresses SHALL never cross the aligned 8-word boundary; index 19'h7FFFF bursts over 19'h7FFF8..19'h7FFFF with no wrap-around.
REQ-013 Only registered sram_rdata or registered state SHALL reach outputs; there is no combinational path from core inputs to ddr_ready or ddr_operation_done.

Reset
REQ-014 While reset_n=0 at a rising edge, the following SHALL hold after that edge:
- state=IDLE, beat counter=0
- ddr_ready=1, ddr_operation_done=0
- sram_ce=0, sram_we=0
- sram_addr, sram_wmask, sram_wdata, ddr_opload_read_data, ddr_pc_read_inst all =0
REQ-015 Reset asserted mid-operation SHALL abort it with no done pulse; any SRAM access issued before reset is not reverted.

Verification
REQ-016 Write: index=19'h00010, mask=64'hFFFF_FFFF_0000_0000, data=64'hDEAD_BEEF_1234_5678 -> T+1 sram_ce=1, sram_we=1, sram_addr=19'h10 with the same mask and data; done at T+2; ready=1 at T+3.
REQ-017 Single read: SRAM word 19'h20 = 64'hA5A5_0000_FFFF_0001, read index 19'h20 -> done at T+3 with ddr_opload_read_data=64'hA5A5_0000_FFFF_0001; ddr_pc_read_inst unchanged.
REQ-018 Burst: SRAM word i = i for i=0x38..0x3F, burst with index=19'h3B -> addresses 0x38..0x3F on T+1..T+8; done at T+10; ddr_pc_read_inst[63:0]=0x38 and [511:448]=0x3F.
REQ-019 Back-to-back: chip_enable held 1 continuously with a write then a read request -> second request accepted only in the cycle after done; requests presented while ready=0 produce no SRAM activity.
REQ-020 Reset mid-burst: reset_n=0 at T+4 of a burst -> next cycle sram_ce=0, ready=1, done never pulses, ddr_pc_read_inst=0.
